mem_load_ctrl: RTL and testbench
================================

// Module: mem_load_ctrl
// PURPOSE
//  Parametrised AXI-stream slave that loads input data into a NUM_BANKS-deep bank of data memories.
//  Supports ping-pong (multi-bank) buffering so the master can fill one bank while the conv engine
//  consumes another. Provides an external address-override mode for debug/weight loading.
//  Sits between the stream master and the input/weight SRAMs, ahead of the conv datapath.
// PARAMETERS
//  DEPTH      30  words per bank; auto-fill closes a bank after address DEPTH-1
//  DATA_W     16  stream/memory data width
//  NUM_BANKS  2   number of banks, >=1; NUM_BANKS=1 reproduces single-buffer operation
//  localparam ADDR_W = $clog2(DEPTH), BANK_W = (NUM_BANKS>1) ? $clog2(NUM_BANKS) : 1
// PORTS
//  clk               in   1          clock
//  reset             in   1          synchronous, active-high
//  s_valid           in   1          stream data valid
//  s_data            in   DATA_W     stream data
//  s_ready           out  1          stream ready (registered)
//  s_last            in   1          end-of-block marker (only with MEM_LOAD_CTRL_TLAST_EN)
//  ext_ctrl_en       in   1          1 = address driven by ext_* inputs
//  ext_load_addr     in   1          load ext_load_addr_val into address
//  ext_load_addr_val in   ADDR_W     address to load
//  ext_incr_addr     in   1          increment address
//  bank_release      in   NUM_BANKS  one-hot pulse: consumer frees bank b
//  bank_full         out  NUM_BANKS  bank b filled, awaiting release
//  mem_wr_en         out  1          memory write strobe = s_valid & s_ready
//  mem_addr          out  ADDR_W     write address within bank
//  mem_bank          out  BANK_W     bank currently written
//  mem_wr_data       out  DATA_W     = s_data (combinational)
//  last_addr         out  ADDR_W     final address of last closed bank (only with macro)
// BEHAVIOUR
//  Reset: state FILL, s_ready=1, mem_addr=0, mem_bank=0, bank_full=0, last_addr=0; reset mid-fill discards progress.
//  Handshake: write occurs in a cycle where s_valid & s_ready; mem_wr_en combinational, zero latency.
//  FILL (auto, ext_ctrl_en=0): each write -> mem_addr+1. Write at DEPTH-1 closes bank: mem_addr<=0,
//   bank_full[mem_bank]<=1, mem_bank<=(mem_bank+1) mod NUM_BANKS. If the new bank is not full
//   (a bank_release for it in the same cycle counts as free) stay FILL, s_ready stays 1;
//   otherwise -> WAIT, s_ready<=0 next cycle.
//  WAIT: s_ready=0, no writes; when bank_full[mem_bank] is 0 or being released -> FILL, s_ready<=1.
//  NUM_BANKS=1: close of the only bank -> WAIT until bank_release[0].
//  Release: bank_release[b] clears bank_full[b]; simultaneous set and release of the same bank -> set wins.
//  Ext mode (ext_ctrl_en=1): ext_load_addr (priority) loads ext_load_addr_val; else ext_incr_addr
//   increments, wrapping DEPTH-1 -> 0; writes still use s_valid & s_ready; no bank close/switch,
//   bank_full unchanged; FILL/WAIT state frozen. Toggling ext_ctrl_en keeps current mem_addr.
//  ext_load_addr_val >= DEPTH: ignored (address held).
// CONFIGURATION
//  MEM_LOAD_CTRL_TLAST_EN defined: s_last port and last_addr output exist; an auto-mode write with
//   s_last=1 closes the bank exactly as a write at DEPTH-1; last_addr <= address of that write.
//  Not defined: no s_last/last_addr ports; banks close only at DEPTH-1.
// STRUCTURE
//  Package mem_load_pkg: typedef enum logic {ST_FILL, ST_WAIT} load_state_t; DEPTH/DATA_W/NUM_BANKS defaults.
//  Sub-module mem_bank_tracker: holds bank_full vector; set/release handling; free-check of next bank.
// TESTING
//  1. DEPTH=30, NUM_BANKS=2, continuous s_valid, no release: 30 writes bank0 addr 0..29, 30 writes bank1,
//     then bank_full=2'b11, s_ready=0 next cycle.
//  2. From test 1, pulse bank_release[0] -> FILL, s_ready=1 next cycle, writes resume at bank0 addr 0.
//  3. Release bank1 in the same cycle as write at addr 29 of bank0 -> no stall; s_ready stays 1; bank1 addr 0 next.
//  4. Ext mode: ext_load_addr_val=5, then 3 ext_incr_addr pulses -> mem_addr 5,6,7,8; load 29 + incr -> 0; bank_full unchanged.
//  5. Reset asserted at bank0 addr 12 -> next cycle mem_addr=0, mem_bank=0, bank_full=0, s_ready=1.
//  6. With MEM_LOAD_CTRL_TLAST_EN: s_last on write at addr 9 -> bank0 closed, last_addr=9, next write bank1 addr 0.

Source files
------------

// File: rtl/mem_load_pkg.sv
// Shared types and default parameters for the memory load controller.
package mem_load_pkg;

  localparam int DEF_DEPTH     = 30;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_BANKS = 2;

  typedef enum logic {ST_FILL, ST_WAIT} load_state_t;

  // Bank index width; a single bank still needs a one-bit index port.
  function automatic int calc_bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_tracker.sv
// Tracks which banks are full and waiting for the consumer, and reports
// whether a queried bank can be written (free now or released this cycle).
module mem_bank_tracker
  import mem_load_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int BANK_W    = calc_bank_w(DEF_NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [BANK_W-1:0]    set_bank,
  input  logic [NUM_BANKS-1:0] rel_mask,
  input  logic [BANK_W-1:0]    check_bank,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 check_free
);

  logic [NUM_BANKS-1:0] set_mask;

  // One-hot mask of the bank being closed this cycle.
  always_comb begin
    set_mask = '0;
    if (set_en) set_mask = NUM_BANKS'(1) << set_bank;
  end

  // Release clears a bank, a close sets it; a close of the same bank wins.
  always_ff @(posedge clk) begin
    if (reset) bank_full <= '0;
    else       bank_full <= (bank_full & ~rel_mask) | set_mask;
  end

  // A bank being released in the current cycle already counts as free.
  always_comb begin
    check_free = ~bank_full[check_bank] | rel_mask[check_bank];
  end

endmodule

// File: rtl/mem_load_ctrl.sv
// AXI-stream slave that fills a set of ping-pong data memory banks.
// Optional feature macro: MEM_LOAD_CTRL_TLAST_EN adds s_last / last_addr so
// a block can close a bank early at the write marked by s_last.
module mem_load_ctrl
  import mem_load_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int BANK_W   = calc_bank_w(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 s_ready,
`ifdef MEM_LOAD_CTRL_TLAST_EN
  input  logic                 s_last,
  output logic [ADDR_W-1:0]    last_addr,
`endif
  input  logic                 ext_ctrl_en,
  input  logic                 ext_load_addr,
  input  logic [ADDR_W-1:0]    ext_load_addr_val,
  input  logic                 ext_incr_addr,
  input  logic [NUM_BANKS-1:0] bank_release,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 mem_wr_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [BANK_W-1:0]    mem_bank,
  output logic [DATA_W-1:0]    mem_wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  load_state_t       state;
  logic              wr;
  logic              close_hit;
  logic              bank_close;
  logic              load_ok;
  logic              check_free;
  logic              next_free;
  logic [BANK_W-1:0] next_bank;
  logic [BANK_W-1:0] check_bank;

  assign wr          = s_valid & s_ready;
  assign mem_wr_en   = wr;
  assign mem_wr_data = s_data;

`ifdef MEM_LOAD_CTRL_TLAST_EN
  assign close_hit = (mem_addr == LAST_ADDR) | s_last;
`else
  assign close_hit = (mem_addr == LAST_ADDR);
`endif

  // Bank rotation, close detection and the free-check target for the tracker.
  always_comb begin
    next_bank  = (mem_bank == LAST_BANK) ? '0 : mem_bank + BANK_W'(1);
    bank_close = ~ext_ctrl_en & (state == ST_FILL) & wr & close_hit;
    check_bank = (state == ST_FILL) ? next_bank : mem_bank;
    next_free  = (next_bank != mem_bank) & check_free;
    load_ok    = int'(ext_load_addr_val) < DEPTH;
  end

  mem_bank_tracker #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .set_en     (bank_close),
    .set_bank   (mem_bank),
    .rel_mask   (bank_release),
    .check_bank (check_bank),
    .bank_full  (bank_full),
    .check_free (check_free)
  );

  // Fill/wait FSM with registered ready, plus address and bank counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FILL;
      s_ready  <= 1'b1;
      mem_addr <= '0;
      mem_bank <= '0;
    end else if (ext_ctrl_en) begin
      if (ext_load_addr) begin
        if (load_ok) mem_addr <= ext_load_addr_val;
      end else if (ext_incr_addr) begin
        mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + ADDR_W'(1);
      end
    end else begin
      case (state)
        ST_FILL: begin
          if (wr) begin
            if (close_hit) begin
              mem_addr <= '0;
              mem_bank <= next_bank;
              if (!next_free) begin
                state   <= ST_WAIT;
                s_ready <= 1'b0;
              end
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (check_free) begin
            state   <= ST_FILL;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_FILL;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_LOAD_CTRL_TLAST_EN
  // Remember the final address written into the most recently closed bank.
  always_ff @(posedge clk) begin
    if (reset)           last_addr <= '0;
    else if (bank_close) last_addr <= mem_addr;
  end
`endif

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed scoreboard bench for mem_load_ctrl (default parameters).
module tb_mem_load_ctrl;

  localparam int DEPTH     = 30;
  localparam int DATA_W    = 16;
  localparam int NUM_BANKS = 2;
  localparam int ADDR_W    = 5;
  localparam int BANK_W    = 1;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                 clk;
  logic                 reset;
  logic                 s_valid;
  logic [DATA_W-1:0]    s_data;
  logic                 s_ready;
`ifdef MEM_LOAD_CTRL_TLAST_EN
  logic                 s_last;
  logic [ADDR_W-1:0]    last_addr;
`endif
  logic                 ext_ctrl_en;
  logic                 ext_load_addr;
  logic [ADDR_W-1:0]    ext_load_addr_val;
  logic                 ext_incr_addr;
  logic [NUM_BANKS-1:0] bank_release;
  logic [NUM_BANKS-1:0] bank_full;
  logic                 mem_wr_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [BANK_W-1:0]    mem_bank;
  logic [DATA_W-1:0]    mem_wr_data;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  mem_load_ctrl #(
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .NUM_BANKS (NUM_BANKS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_valid           (s_valid),
    .s_data            (s_data),
    .s_ready           (s_ready),
`ifdef MEM_LOAD_CTRL_TLAST_EN
    .s_last            (s_last),
    .last_addr         (last_addr),
`endif
    .ext_ctrl_en       (ext_ctrl_en),
    .ext_load_addr     (ext_load_addr),
    .ext_load_addr_val (ext_load_addr_val),
    .ext_incr_addr     (ext_incr_addr),
    .bank_release      (bank_release),
    .bank_full         (bank_full),
    .mem_wr_en         (mem_wr_en),
    .mem_addr          (mem_addr),
    .mem_bank          (mem_bank),
    .mem_wr_data       (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stream input, queue the write it should cause, then
  // advance to just after the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data,
                               input logic exp_wr, input int bank, input int addr);
    wr_t e;
    s_valid = valid;
    s_data  = data;
    if (exp_wr) begin
      e.bank = BANK_W'(bank);
      e.addr = ADDR_W'(addr);
      e.data = data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Every write strobe seen mid-cycle must match the oldest queued write.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {16'h0, mem_wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_bank", 32'(mem_bank), 32'(e.bank));
        checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(mem_wr_data), 32'(e.data));
      end
    end
  end

  initial begin
    reset             = 1'b1;
    s_valid           = 1'b0;
    s_data            = '0;
`ifdef MEM_LOAD_CTRL_TLAST_EN
    s_last            = 1'b0;
`endif
    ext_ctrl_en       = 1'b0;
    ext_load_addr     = 1'b0;
    ext_load_addr_val = '0;
    ext_incr_addr     = 1'b0;
    bank_release      = '0;

    $display("[TB] reset state");
    applyStimulus(0, 16'h0, 0, 0, 0);
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("rst_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_bank", 32'(mem_bank), 32'd0);
    checkOutput("rst_full", 32'(bank_full), 32'd0);
    reset = 1'b0;

    $display("[TB] fill both banks without release");
    for (int i = 0; i < 2 * DEPTH; i++)
      applyStimulus(1, DATA_W'(16'hA000 + i), 1, i / DEPTH, i % DEPTH);
    checkOutput("stall_ready", 32'(s_ready), 32'd0);
    checkOutput("stall_full", 32'(bank_full), 32'd3);
    checkOutput("stall_bank", 32'(mem_bank), 32'd0);
    checkOutput("stall_addr", 32'(mem_addr), 32'd0);
    applyStimulus(1, 16'hEEEE, 0, 0, 0);
    checkOutput("stall_hold", 32'(s_ready), 32'd0);

    $display("[TB] release bank0 resumes filling");
    s_valid = 1'b0;
    bank_release = 2'b01;
    applyStimulus(0, 16'h0, 0, 0, 0);
    bank_release = 2'b00;
    checkOutput("rel_ready", 32'(s_ready), 32'd1);
    checkOutput("rel_full", 32'(bank_full), 32'd2);
    checkOutput("rel_addr", 32'(mem_addr), 32'd0);

    $display("[TB] release bank1 on the closing write of bank0");
    for (int i = 0; i < DEPTH; i++) begin
      bank_release = (i == DEPTH - 1) ? 2'b10 : 2'b00;
      applyStimulus(1, DATA_W'(16'hB000 + i), 1, 0, i);
    end
    bank_release = 2'b00;
    checkOutput("nostall_ready", 32'(s_ready), 32'd1);
    checkOutput("nostall_full", 32'(bank_full), 32'd1);
    checkOutput("nostall_bank", 32'(mem_bank), 32'd1);
    applyStimulus(1, 16'hB100, 1, 1, 0);
    checkOutput("nostall_addr", 32'(mem_addr), 32'd1);

    $display("[TB] external address control");
    s_valid = 1'b0;
    ext_ctrl_en = 1'b1;
    ext_load_addr = 1'b1;
    ext_load_addr_val = 5'd5;
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("ext_load5", 32'(mem_addr), 32'd5);
    ext_load_addr = 1'b0;
    ext_incr_addr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 16'h0, 0, 0, 0);
      checkOutput("ext_incr", 32'(mem_addr), 32'(5 + k));
    end
    ext_incr_addr = 1'b0;
    ext_load_addr = 1'b1;
    ext_load_addr_val = 5'd29;
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("ext_load29", 32'(mem_addr), 32'd29);
    ext_load_addr = 1'b0;
    ext_incr_addr = 1'b1;
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("ext_wrap", 32'(mem_addr), 32'd0);
    ext_incr_addr = 1'b0;
    ext_load_addr = 1'b1;
    ext_load_addr_val = 5'd31;
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("ext_badload", 32'(mem_addr), 32'd0);
    ext_load_addr_val = 5'd7;
    applyStimulus(0, 16'h0, 0, 0, 0);
    ext_load_addr = 1'b0;
    applyStimulus(1, 16'hC0DE, 1, 1, 7);
    checkOutput("ext_wr_addr", 32'(mem_addr), 32'd7);
    checkOutput("ext_full", 32'(bank_full), 32'd1);
    checkOutput("ext_bank", 32'(mem_bank), 32'd1);
    ext_ctrl_en = 1'b0;
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("ext_exit_addr", 32'(mem_addr), 32'd7);

    $display("[TB] auto fill resumes from kept address");
    for (int a = 7; a < DEPTH; a++) begin
      bank_release = (a == DEPTH - 1) ? 2'b01 : 2'b00;
      applyStimulus(1, DATA_W'(16'hD000 + a), 1, 1, a);
    end
    bank_release = 2'b00;
    checkOutput("wrap_bank", 32'(mem_bank), 32'd0);
    checkOutput("wrap_full", 32'(bank_full), 32'd2);
    checkOutput("wrap_ready", 32'(s_ready), 32'd1);
    for (int a = 0; a < 12; a++)
      applyStimulus(1, DATA_W'(16'hE000 + a), 1, 0, a);
    checkOutput("pre_rst_addr", 32'(mem_addr), 32'd12);

    $display("[TB] reset mid-fill");
    s_valid = 1'b0;
    reset = 1'b1;
    applyStimulus(0, 16'h0, 0, 0, 0);
    reset = 1'b0;
    checkOutput("mid_rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("mid_rst_bank", 32'(mem_bank), 32'd0);
    checkOutput("mid_rst_full", 32'(bank_full), 32'd0);
    checkOutput("mid_rst_ready", 32'(s_ready), 32'd1);

`ifdef MEM_LOAD_CTRL_TLAST_EN
    $display("[TB] early close with s_last");
    for (int a = 0; a < 10; a++) begin
      s_last = (a == 9);
      applyStimulus(1, DATA_W'(16'hF000 + a), 1, 0, a);
    end
    s_last = 1'b0;
    checkOutput("tlast_last_addr", 32'(last_addr), 32'd9);
    checkOutput("tlast_full", 32'(bank_full), 32'd1);
    checkOutput("tlast_bank", 32'(mem_bank), 32'd1);
    checkOutput("tlast_addr", 32'(mem_addr), 32'd0);
    applyStimulus(1, 16'hF100, 1, 1, 0);
`else
    applyStimulus(1, 16'hF000, 1, 0, 0);
    checkOutput("post_rst_addr", 32'(mem_addr), 32'd1);
`endif

    s_valid = 1'b0;
    applyStimulus(0, 16'h0, 0, 0, 0);
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
